manchester_rx_ctrl: RTL and testbench

MANCHESTER_RX_CTRL -- requirements
Module: manchester_rx_ctrl

---
 rtl/manchester_rx_ctrl_if.sv | 23 ++
 rtl/manchester_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_manchester_rx_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_rx_ctrl_if.sv
// Chip-in / byte-out bundle of the Manchester receive controller.
// slave is the receiver side, master drives chips and consumes bytes.
interface manchester_rx_ctrl_if;
   logic       chip_in;
   logic       chip_valid;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_active;
   logic       frame_done;
   logic       viol;
   logic       ovf;

   modport slave (
      input  chip_in, chip_valid, byte_ready,
      output byte_out, byte_valid, frame_active, frame_done, viol, ovf
   );

   modport master (
      output chip_in, chip_valid, byte_ready,
      input  byte_out, byte_valid, frame_active, frame_done, viol, ovf
   );
endinterface

// File: rtl/manchester_rx_ctrl.sv
// Manchester receive controller: hunts a 16-chip sync word, then decodes FRAME_LEN bytes.
// Define MANCH_VIOL_CHECK_EN to flag 00/11 chip pairs as violations and abort the frame.
module manchester_rx_ctrl #(
   parameter logic [15:0] SYNC_CHIPS = 16'hA666,
   parameter int unsigned FRAME_LEN  = 4
) (
   input logic                  clk,
   input logic                  rst,
   manchester_rx_ctrl_if.slave  bus
);

   typedef enum logic {HUNT, PAYLOAD} state_e;

   localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

   state_e      state_q, state_d;
   logic [15:0] sr_q, sr_d, sr_shift;
   logic [3:0]  chip_cnt_q, chip_cnt_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        frame_done_q, frame_done_d;
   logic        viol_q, viol_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  decoded;
   logic        pair_bad;

   assign sr_shift = {sr_q[14:0], bus.chip_in};

   // A chip pair decodes to 1 only when it is 10; 01, 00 and 11 all read as 0.
   always_comb begin
      decoded = '0;
      for (int i = 0; i < 8; i++) begin
         decoded[7-i] = sr_shift[15-2*i] & ~sr_shift[14-2*i];
      end
   end

`ifdef MANCH_VIOL_CHECK_EN
   // An odd chip count means this chip completes an even-aligned pair.
   assign pair_bad = chip_cnt_q[0] & (sr_q[0] == bus.chip_in);
`else
   assign pair_bad = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      sr_d         = sr_q;
      chip_cnt_d   = chip_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = byte_valid_q;
      frame_done_d = 1'b0;
      viol_d       = 1'b0;
      ovf_d        = ovf_q;

      if (byte_valid_q && bus.byte_ready) begin
         byte_valid_d = 1'b0;
      end

      if (bus.chip_valid) begin
         sr_d = sr_shift;
         unique case (state_q)
            HUNT: begin
               if (sr_shift == SYNC_CHIPS) begin
                  state_d    = PAYLOAD;
                  chip_cnt_d = '0;
                  byte_cnt_d = '0;
               end
            end
            PAYLOAD: begin
               chip_cnt_d = chip_cnt_q + 4'd1;
               if (pair_bad) begin
                  viol_d     = 1'b1;
                  state_d    = HUNT;
                  sr_d       = '0;
                  chip_cnt_d = '0;
                  byte_cnt_d = '0;
               end else if (chip_cnt_q == 4'd15) begin
                  // A byte landing on a handshake replaces the old one; otherwise it is dropped.
                  if (!byte_valid_q || bus.byte_ready) begin
                     byte_out_d   = decoded;
                     byte_valid_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  byte_cnt_d = byte_cnt_q + 8'd1;
                  if (byte_cnt_q == LAST_BYTE) begin
                     frame_done_d = 1'b1;
                     state_d      = HUNT;
                     sr_d         = '0;
                     byte_cnt_d   = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         chip_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         viol_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         chip_cnt_q   <= chip_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         frame_done_q <= frame_done_d;
         viol_q       <= viol_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.byte_out     = byte_out_q;
   assign bus.byte_valid   = byte_valid_q;
   assign bus.frame_active = (state_q == PAYLOAD);
   assign bus.frame_done   = frame_done_q;
   assign bus.viol         = viol_q;
   assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_manchester_rx_ctrl.sv
// Bench for manchester_rx_ctrl: directed frames plus randomized bytes and chip gaps,
// checked against a byte-level Manchester encode/decode model (honours MANCH_VIOL_CHECK_EN).
module tb_manchester_rx_ctrl;

   localparam logic [15:0] SYNC      = 16'hA666;
   localparam int          FRAME_LEN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   manchester_rx_ctrl_if bus ();

   manchester_rx_ctrl #(.SYNC_CHIPS(SYNC), .FRAME_LEN(FRAME_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: Manchester with 1 -> chips 10, 0 -> chips 01; a pair reads 1 only if it is 10.
   function automatic logic [15:0] enc(input logic [7:0] b);
      logic [15:0] c = '0;
      for (int i = 0; i < 8; i++) c[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
      return c;
   endfunction

   function automatic logic [7:0] dec(input logic [15:0] c);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b[i] = (c[2*i +: 2] == 2'b10);
      return b;
   endfunction

   // Output monitor, sampled on the falling edge.
   logic [7:0] got_q[$];
   int done_cnt = 0;
   int done_at  = -1;
   int viol_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.byte_out);
         if (bus.frame_done) begin
            done_cnt++;
            done_at = got_q.size();
            check("done_with_valid", 32'(bus.byte_valid), 32'd1);
         end
         if (bus.viol) viol_cnt++;
      end
   end

   // Inputs change #1 after the rising edge; tasks start and end at that point.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_chip(input logic c, input int gap);
      bus.chip_valid = 1'b0;
      idle(gap);
      bus.chip_in    = c;
      bus.chip_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.chip_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] c, input int max_gap);
      for (int i = 15; i >= 0; i--) send_chip(c[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
   endtask

   task automatic send_frame(input logic [31:0] f, input int max_gap);
      send_word(SYNC, max_gap);
      for (int i = 0; i < FRAME_LEN; i++) send_word(enc(f[31-8*i -: 8]), max_gap);
      idle(3);
   endtask

   task automatic expect_frame(input string tag, input logic [31:0] f, input int d0);
      check({tag, "_count"}, 32'(got_q.size()), 32'(FRAME_LEN));
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (got_q.size() > i) check({tag, "_byte"}, 32'(got_q[i]), 32'(f[31-8*i -: 8]));
      end
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_done_at_last"}, 32'(done_at), 32'(FRAME_LEN));
      check({tag, "_inactive"}, 32'(bus.frame_active), 32'd0);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.chip_valid = 1'b0;
      bus.chip_in    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_q.delete();
      done_at = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, v0;
      logic [31:0] f;
      logic [15:0] bad;

      bus.chip_in    = 1'b0;
      bus.chip_valid = 1'b0;
      bus.byte_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_byte_out", 32'(bus.byte_out), 32'h00);
      check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
      check("rst_frame_active", 32'(bus.frame_active), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_viol", 32'(bus.viol), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);

      // Basic frame with edge-value bytes
      bus.byte_ready = 1'b1;
      d0 = done_cnt;
      send_word(SYNC, 0);
      check("active_after_sync", 32'(bus.frame_active), 32'd1);
      for (int i = 0; i < FRAME_LEN; i++) send_word(enc(32'h0180FF00 >> (24 - 8*i)), 0);
      idle(3);
      expect_frame("basic", 32'h0180FF00, d0);

      // Consumer stalled for the whole frame: first byte held, rest dropped
      do_reset();
      bus.byte_ready = 1'b0;
      d0 = done_cnt;
      send_frame(32'h12345678, 0);
      check("stall_byte_out", 32'(bus.byte_out), 32'h12);
      check("stall_byte_valid", 32'(bus.byte_valid), 32'd1);
      check("stall_ovf", 32'(bus.ovf), 32'd1);
      check("stall_done", 32'(done_cnt - d0), 32'd1);
      bus.byte_ready = 1'b1;
      idle(2);
      check("stall_drained", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("stall_drained_byte", 32'(got_q[0]), 32'h12);
      check("stall_valid_cleared", 32'(bus.byte_valid), 32'd0);
      check("stall_ovf_sticky", 32'(bus.ovf), 32'd1);

      // Byte completion on the same edge as a handshake
      do_reset();
      bus.byte_ready = 1'b0;
      d0 = done_cnt;
      f = 32'hA1B2C3D4;
      send_word(SYNC, 0);
      send_word(enc(f[31:24]), 0);
      for (int i = 15; i >= 1; i--) send_chip(enc(f[23:16])/*chips*/ >> i, 0);
      bus.byte_ready = 1'b1;
      send_chip(enc(f[23:16]) >> 0, 0);
      send_word(enc(f[15:8]), 0);
      send_word(enc(f[7:0]), 0);
      idle(3);
      expect_frame("coincide", f, d0);
      check("coincide_no_ovf", 32'(bus.ovf), 32'd0);

      // Near-miss sync (0xD4) must not open a frame
      do_reset();
      send_word(enc(8'hD4), 0);
      check("near_sync_idle", 32'(bus.frame_active), 32'd0);
      send_word(SYNC, 0);
      check("true_sync_active", 32'(bus.frame_active), 32'd1);
      got_q.delete();
      d0 = done_cnt;
      f = $urandom();
      for (int i = 0; i < FRAME_LEN; i++) send_word(enc(f[31-8*i -: 8]), 0);
      idle(3);
      expect_frame("after_near_sync", f, d0);

      // Invalid 11 pair in the second byte
      do_reset();
      d0 = done_cnt;
      v0 = viol_cnt;
      bad = enc(8'h5A);
      bad[15:14] = 2'b11;
      send_word(SYNC, 0);
      send_word(enc(8'hC3), 0);
      send_word(bad, 0);
      send_word(enc(8'h00), 0);
      send_word(enc(8'h00), 0);
      idle(3);
`ifdef MANCH_VIOL_CHECK_EN
      check("viol_pulse", 32'(viol_cnt - v0), 32'd1);
      check("viol_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("viol_first_byte", 32'(got_q[0]), 32'hC3);
      check("viol_no_done", 32'(done_cnt - d0), 32'd0);
      check("viol_inactive", 32'(bus.frame_active), 32'd0);
`else
      check("noviol_pulse", 32'(viol_cnt - v0), 32'd0);
      expect_frame("noviol", {8'hC3, dec(bad), 8'h00, 8'h00}, d0);
`endif

      // Reset mid-frame with a byte pending
      do_reset();
      bus.byte_ready = 1'b0;
      d0 = done_cnt;
      send_word(SYNC, 0);
      send_word(enc(8'hA5), 0);
      for (int i = 15; i >= 8; i--) send_chip(enc(8'h3C) >> i, 0);
      check("pending_before_rst", 32'(bus.byte_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_byte_out", 32'(bus.byte_out), 32'h00);
      check("midrst_byte_valid", 32'(bus.byte_valid), 32'd0);
      check("midrst_frame_active", 32'(bus.frame_active), 32'd0);
      check("midrst_frame_done", 32'(bus.frame_done), 32'd0);
      check("midrst_viol", 32'(bus.viol), 32'd0);
      check("midrst_ovf", 32'(bus.ovf), 32'd0);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      bus.byte_ready = 1'b1;
      got_q.delete();
      d0 = done_cnt;
      f = $urandom();
      send_frame(f, 0);
      expect_frame("post_rst", f, d0);

      // Random bytes, gapless then with random 0..5 idle gaps between chips
      for (int n = 0; n < 4; n++) begin
         f = $urandom();
         got_q.delete();
         d0 = done_cnt;
         send_frame(f, 0);
         expect_frame("rand_gapless", f, d0);
         got_q.delete();
         d0 = done_cnt;
         send_frame(f, 5);
         expect_frame("rand_gapped", f, d0);
      end
      check("rand_no_ovf", 32'(bus.ovf), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
